// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: round-robin with a bounded port-1 lock burst,
// 1-cycle reads, range/byte-enable filtering. Optional write trace: DM_ARB_TRACE_EN.
module dm_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  input  logic [31:0] p0_pc,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  input  logic        p1_lock,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned IW = 10;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] BURST_MAX = CW'(8);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e          last_q, last_d;
  logic [CW-1:0]  burst_q, burst_d;
  logic           gnt0, gnt1;

  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic [BW-1:0]  sel_be;
  logic           in_range;
  logic           be_zero;
  logic           any_gnt;

  logic           rvalid0_q, rvalid1_q;
  logic [DW-1:0]  rdata0_q, rdata1_q;
  logic           err0_q, err1_q;

  // Grant decision and next state of last-winner / burst counter
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    last_d  = last_q;
    burst_d = burst_q;
    if (!reset) begin
      if (p0_req && p1_req) begin
        if (last_q == PORT1 && p1_lock && burst_q < BURST_MAX) begin
          gnt1 = 1'b1;
        end else if (last_q == PORT1) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
    end
    if (gnt0) begin
      last_d = PORT0;
    end else if (gnt1) begin
      last_d = PORT1;
    end
    if (gnt0 || !p1_lock) begin
      burst_d = '0;
    end else if (gnt1 && burst_q < BURST_MAX) begin
      burst_d = burst_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= PORT1;
      burst_q <= '0;
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  // Granted port's request steers the memory interface
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    if (gnt0) begin
      sel_we    = p0_we;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
      sel_be    = p0_be;
    end else if (gnt1) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
      sel_be    = p1_be;
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign in_range  = (sel_addr[AW-1:12] == '0);
  assign be_zero   = sel_we && (sel_be == '0);

  assign mem_en    = any_gnt && in_range && !be_zero;
  assign mem_we    = mem_en && sel_we;
  assign mem_addr  = sel_addr[IW+1:2];
  assign mem_wdata = sel_wdata;
  assign mem_be    = sel_we ? sel_be : BW'(0);

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;

  // Read-return and error tracking; rdata holds between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      rvalid0_q <= gnt0 && mem_en && !sel_we;
      rvalid1_q <= gnt1 && mem_en && !sel_we;
      err0_q    <= gnt0 && !in_range;
      err1_q    <= gnt1 && !in_range;
      if (rvalid0_q) begin
        rdata0_q <= mem_rdata;
      end
      if (rvalid1_q) begin
        rdata1_q <= mem_rdata;
      end
    end
  end

  // Memory data arrives in the return cycle, so it is forwarded directly then;
  // a reset in that cycle cancels the return.
  assign p0_rvalid = rvalid0_q && !reset;
  assign p1_rvalid = rvalid1_q && !reset;
  assign p0_rdata  = p0_rvalid ? mem_rdata : rdata0_q;
  assign p1_rdata  = p1_rvalid ? mem_rdata : rdata1_q;
  assign p0_err    = err0_q;
  assign p1_err    = err1_q;

`ifdef DM_ARB_TRACE_EN
  logic [AW-1:0] sel_pc;
  logic [1:0]    unused_lsb;

  assign sel_pc     = gnt0 ? p0_pc : AW'(0);
  assign unused_lsb = sel_addr[1:0];

  always_ff @(posedge clk) begin
    if (mem_we && mem_be == 4'b1111) begin
      $display("%d@%h: *%h <= %h", $time, sel_pc, {sel_addr[AW-1:2], 2'b00}, sel_wdata);
    end
  end
`else
  logic unused_trace;

  assign unused_trace = ^{p0_pc, sel_addr[1:0]};
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: memory emulator, cycle-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p0_pc, p1_addr, p1_wdata;
  logic [3:0]  p0_be, p1_be;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_be(p0_be), .p0_pc(p0_pc),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_be(p1_be), .p1_lock(p1_lock),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h9e37_79b1;
  endfunction

  // Memory emulator: synchronous single-port RAM with byte enables
  logic [31:0] ram [1024];
  bit          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Reference model: what the outputs must be, derived from the arbitration rules
  logic [31:0] ref_mem [1024];
  int          m_last;
  int          m_cnt;
  bit          m_valid = 1'b0;
  bit          m_pend [2];
  bit          m_err [2];
  logic [31:0] m_pdata [2];
  logic [31:0] m_hold [2];

  always @(negedge clk) begin : cmp
    int          g;
    logic [31:0] a, wd, rd;
    logic [3:0]  be;
    bit          we, inr, en, rv;
    g = 0;
    if (!reset) begin
      if (p0_req && p1_req) begin
        if (m_last == 1 && p1_lock && m_cnt < 8) g = 2;
        else g = (m_last == 1) ? 1 : 2;
      end else if (p0_req) g = 1;
      else if (p1_req) g = 2;
    end
    a   = (g == 1) ? p0_addr  : (g == 2) ? p1_addr  : 32'h0;
    wd  = (g == 1) ? p0_wdata : (g == 2) ? p1_wdata : 32'h0;
    be  = (g == 1) ? p0_be    : (g == 2) ? p1_be    : 4'h0;
    we  = (g == 1) ? p0_we    : (g == 2) ? p1_we    : 1'b0;
    inr = (a[31:12] == 20'h0);
    en  = (g != 0) && inr && !(we && be == 4'h0);
    if (m_valid) begin
      chk("m_p0_gnt", 32'(p0_gnt), 32'(g == 1));
      chk("m_p1_gnt", 32'(p1_gnt), 32'(g == 2));
      chk("m_mem_en", 32'(mem_en), 32'(en));
      if (en || g == 0) begin
        chk("m_mem_we", 32'(mem_we), 32'(en && we));
        chk("m_mem_addr", 32'(mem_addr), 32'(a[11:2]));
      end
      if (en) chk("m_mem_be", 32'(mem_be), 32'(we ? be : 4'h0));
      if ((en && we) || g == 0) chk("m_mem_wdata", mem_wdata, wd);
      for (int i = 0; i < 2; i++) begin
        rv = m_pend[i] && !reset;
        rd = rv ? m_pdata[i] : m_hold[i];
        chk($sformatf("m_p%0d_rvalid", i), 32'(i == 0 ? p0_rvalid : p1_rvalid), 32'(rv));
        chk($sformatf("m_p%0d_rdata", i), i == 0 ? p0_rdata : p1_rdata, rd);
        chk($sformatf("m_p%0d_err", i), 32'(i == 0 ? p0_err : p1_err), 32'(m_err[i]));
      end
    end
    if (reset) begin
      if (!m_valid)
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
      m_valid = 1'b1;
      m_last  = 1;
      m_cnt   = 0;
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 1'b0; m_err[i] = 1'b0; m_hold[i] = 32'h0; m_pdata[i] = 32'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_pend[i]) m_hold[i] = m_pdata[i];
        m_pend[i]  = (g == i + 1) && !we && inr;
        m_err[i]   = (g == i + 1) && !inr;
        m_pdata[i] = ref_mem[a[11:2]];
      end
      if (en && we)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[a[11:2]][8*b +: 8] = wd[8*b +: 8];
      if (g == 1) m_last = 0;
      else if (g == 2) m_last = 1;
      if (g == 1 || !p1_lock) m_cnt = 0;
      else if (g == 2 && m_cnt < 8) m_cnt++;
    end
  end

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0; p0_pc = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0; p1_lock = 0;
  endtask

  task automatic drv0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] pc);
    p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be; p0_pc = pc;
  endtask

  task automatic drv1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic lock);
    p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be; p1_lock = lock;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [3:0] tie_p0;
    tie_p0 = 4'b0101;
    idle();
    reset = 1'b1;
    drv0(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    drv1(1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_p0_gnt", 32'(p0_gnt), 32'h0);
    chk("rst_p1_gnt", 32'(p1_gnt), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    tick();
    reset = 1'b0;
    idle();

    @(negedge clk);
    chk("post_rst_p0_rvalid", 32'(p0_rvalid), 32'h0);
    chk("post_rst_p0_rdata", p0_rdata, 32'h0);
    chk("post_rst_p1_rdata", p1_rdata, 32'h0);
    chk("post_rst_err", 32'({p0_err, p1_err}), 32'h0);
    chk("idle_mem_addr", 32'(mem_addr), 32'h0);
    chk("idle_mem_wdata", mem_wdata, 32'h0);
    tick();

    // Tie after reset alternates starting with port 0
    for (int k = 0; k < 4; k++) begin
      drv0(1'b0, 32'h40, 32'h0, 4'h0, 32'h0);
      drv1(1'b0, 32'h80, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk("tie_p0_gnt", 32'(p0_gnt), 32'(tie_p0[k]));
      chk("tie_p1_gnt", 32'(p1_gnt), 32'(!tie_p0[k]));
      tick();
    end
    idle();

    // Write then read back
    drv0(1'b1, 32'h10, 32'h1234_5678, 4'hf, 32'h100);
    @(negedge clk);
    chk("wr_mem_we", 32'({mem_en, mem_we}), 32'h3);
    chk("wr_mem_addr", 32'(mem_addr), 32'h4);
    chk("wr_mem_be", 32'(mem_be), 32'hf);
    tick();
    drv0(1'b0, 32'h10, 32'h0, 4'hf, 32'h104);
    @(negedge clk);
    chk("rd_mem_be", 32'({mem_we, mem_be}), 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("rd_p0_rvalid", 32'(p0_rvalid), 32'h1);
    chk("rd_p0_rdata", p0_rdata, 32'h1234_5678);
    tick();
    @(negedge clk);
    chk("hold_p0_rvalid", 32'(p0_rvalid), 32'h0);
    chk("hold_p0_rdata", p0_rdata, 32'h1234_5678);
    tick();

    // Partial byte-enable write merges into the existing word
    drv1(1'b1, 32'h10, 32'haabb_ccdd, 4'b0011, 1'b0);
    tick();
    drv1(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("be_p1_rdata", p1_rdata, 32'h1234_ccdd);
    tick();

    // Zero byte-enable write: granted, no memory access, no error
    drv0(1'b1, 32'h10, 32'hffff_ffff, 4'h0, 32'h200);
    @(negedge clk);
    chk("be0_gnt_en", 32'({p0_gnt, mem_en}), 32'h2);
    tick();
    drv0(1'b0, 32'h10, 32'h0, 4'h0, 32'h204);
    @(negedge clk);
    chk("be0_p0_err", 32'(p0_err), 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("be0_rdata", p0_rdata, 32'h1234_ccdd);
    tick();

    // Out-of-range read
    drv1(1'b0, 32'h0000_1004, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("oor_gnt_en", 32'({p1_gnt, mem_en}), 32'h2);
    tick();
    idle();
    @(negedge clk);
    chk("oor_p1_err", 32'(p1_err), 32'h1);
    chk("oor_p1_rvalid", 32'(p1_rvalid), 32'h0);
    tick();
    @(negedge clk);
    chk("oor_err_pulse", 32'(p1_err), 32'h0);
    tick();

    // Lock burst: eight port-1 grants, then one port-0 grant, twice
    for (int k = 0; k < 18; k++) begin
      drv0(1'b0, 32'h40, 32'h0, 4'h0, 32'h0);
      drv1(1'b0, 32'h44, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      chk("lock_gnt", 32'({p0_gnt, p1_gnt}), (k == 8 || k == 17) ? 32'h2 : 32'h1);
      tick();
    end
    idle();
    tick();

    // Saturated burst count lets a late port-0 request in immediately
    drv1(1'b0, 32'h48, 32'h0, 4'h0, 1'b1);
    repeat (10) tick();
    drv0(1'b0, 32'h40, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("sat_p0_gnt", 32'(p0_gnt), 32'h1);
    tick();
    idle();
    tick();

    // Dropping lock clears the burst count
    drv1(1'b0, 32'h4c, 32'h0, 4'h0, 1'b1);
    repeat (7) tick();
    p1_lock = 1'b0;
    tick();
    drv0(1'b0, 32'h40, 32'h0, 4'h0, 32'h0);
    p1_lock = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("clr_p1_gnt", 32'(p1_gnt), 32'h1);
      tick();
    end
    idle();
    tick();

    // Full-word writes from both ports (traced when enabled)
    drv0(1'b1, 32'h20, 32'hdead_beef, 4'hf, 32'h0000_3004);
    tick();
    idle();
    drv1(1'b1, 32'h24, 32'h0bad_f00d, 4'hf, 1'b0);
    tick();
    idle();

    // Reset in the cycle after a read grant cancels the return
    drv0(1'b0, 32'h20, 32'h0, 4'h0, 32'h0);
    tick();
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("rstrd_rvalid", 32'(p0_rvalid), 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstrd_rvalid2", 32'(p0_rvalid), 32'h0);
    chk("rstrd_rdata", p0_rdata, 32'h0);
    tick();

    // First tie after reset goes to port 0
    drv0(1'b0, 32'h24, 32'h0, 4'h0, 32'h0);
    drv1(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("tie2_p0_gnt", 32'({p0_gnt, p1_gnt}), 32'h2);
    tick();
    idle();
    @(negedge clk);
    chk("tie2_p0_rdata", p0_rdata, 32'h0bad_f00d);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 p0_req / p1_req  input  1  access request, port 0 = CPU MEM stage, port 1 = DMA/debug loader.
REQ-004 pN_we  input  1  1 = write, 0 = read (N = 0,1).
REQ-005 pN_addr  input  32  byte address; word index = addr[11:2].
REQ-006 pN_wdata  input  32  write data.
REQ-007 pN_be  input  4  byte enables for writes; ignored on reads.
REQ-008 p1_lock  input  1  port 1 requests back-to-back grants (burst).
REQ-009 p0_pc  input  32  PC of the port-0 instruction, used only for the trace.
REQ-010 pN_gnt  output  1  request accepted this cycle (combinational from registered state and request inputs).
REQ-011 pN_rvalid  output  1  read data valid, registered.
REQ-012 pN_rdata  output  32  read data, registered.
REQ-013 pN_err  output  1  one-cycle pulse, registered: accepted request had addr[31:12] != 0.
REQ-014 mem_en / mem_we  output  1  single-port memory enable and write strobe.
REQ-015 mem_addr  output  10  memory word index.
REQ-016 mem_wdata / mem_be  output  32 / 4  memory write data and byte enables.
REQ-017 mem_rdata  input  32  memory read data, valid one cycle after mem_en with mem_we = 0.

Function
REQ-018 At most one gnt per cycle; the granted port drives the mem_* signals in the same cycle.
REQ-019 When only one port requests, that port is granted.
REQ-020 When both ports request, round-robin applies: the port that did not win the last grant wins; the last-winner register updates on every grant.
REQ-021 Lock: while port 1 holds the grant and p1_lock = 1, port 1 keeps priority over port 0; burst counter increments per port-1 grant.
REQ-022 When the burst counter reaches 8 and p0_req = 1, port 0 is granted next; the counter clears on any port-0 grant or when p1_lock = 0.
REQ-023 Read latency is exactly 1 cycle: pN_rvalid = 1 and pN_rdata = mem_rdata in the cycle after the read grant; otherwise rvalid = 0 and rdata holds its last value.
REQ-024 Write: mem_we = 1 and mem_be = pN_be; mem_be = 4'b0000 and mem_we = 0 for reads.
REQ-025 Out-of-range request (addr[31:12] != 0): granted, mem_en = 0, pN_err pulses the next cycle, and no rvalid is produced.
REQ-026 A request with pN_be = 0 on a write: granted, mem_en = 0, no error.
REQ-027 No request: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.

Reset
REQ-028 During reset: gnt = 0 on both ports and mem_en = 0 regardless of requests.
REQ-029 After reset: rvalid = 0, rdata = 0, err = 0, burst counter = 0, last-winner = port 1, so port 0 wins the first tie.
REQ-030 Reset asserted one cycle after a read grant suppresses that rvalid.

Configuration
REQ-031 With DM_ARB_TRACE_EN defined, each granted in-range write to mem_be = 4'b1111 prints "%d@%h: *%h <= %h" with $time, the PC (p0_pc for port 0, 32'h0 for port 1), the word-aligned address and wdata.
REQ-032 Without DM_ARB_TRACE_EN defined, no simulation output is produced and the logic is identical.

Verification
REQ-033 Write then read: p0 writes 32'h1234_5678 to 0x10, then p0 reads 0x10 -> read rvalid one cycle later with rdata 32'h1234_5678.
REQ-034 Tie after reset: p0 and p1 both request for 4 cycles -> grants go p0, p1, p0, p1.
REQ-035 Lock starvation bound: p1_lock = 1 with p1 requesting continuously and p0 requesting from cycle 0 -> 8 p1 grants, then one p0 grant, then p1 resumes.
REQ-036 Out-of-range: p1 read of 0x0000_1004 -> p1_gnt = 1, mem_en = 0, p1_err = 1 next cycle, p1_rvalid = 0.
REQ-037 Reset mid-read: p0 read grant in cycle n, reset in cycle n+1 -> p0_rvalid = 0 and rdata = 0 after reset.
REQ-038 Trace: DM_ARB_TRACE_EN defined, p0 write of 32'hdead_beef to 0x20 at PC 32'h0000_3004 -> exactly one trace line "...@00003004: *00000020 <= deadbeef".
